// File: rtl/apb_master_if.sv
// apb_master_if: groups the command, response and APB bus signals of apb_master.
//   Command  : cmd_valid/cmd_ready handshake, cmd_addr, cmd_write, cmd_wdata, cmd_strb
//   Response : rsp_valid/rsp_ready handshake, rsp_rdata, rsp_err, rsp_tmo
//   APB      : paddr, pwrite, psel, penable, pwdata, pstrb (out), prdata, pready, pslverr (in)
// Modport master is the bridge side; modport slave is the environment side (command source,
// response sink and APB slave).
interface apb_master_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    localparam int unsigned SW = DW / 8;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_write;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_tmo;

    logic [AW-1:0] paddr;
    logic          pwrite;
    logic          psel;
    logic          penable;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
        input  rsp_ready,
        output paddr, pwrite, psel, penable, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
        output rsp_ready,
        input  paddr, pwrite, psel, penable, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB master bridge.
// Takes one read/write command, runs an APB SETUP->ACCESS transfer, waits for pready (bounded
// by a timeout of TMO wait cycles, 0 disables it) and returns read data, slave error and
// timeout status on the response handshake.
// Ports:
//   pclk   - clock
//   preset - synchronous active-high reset
//   bus    - apb_master_if.master (command, response and APB signals)
// All APB and response outputs are registered; cmd_ready is combinational from state and reset.
module apb_master #(
    parameter int unsigned DW  = 32,
    parameter int unsigned AW  = 5,
    parameter int unsigned TMO = 16
) (
    input logic          pclk,
    input logic          preset,
    apb_master_if.master bus
);
    localparam int unsigned SW = DW / 8;
    // Keep the counter at least one bit wide even when the timeout is disabled.
    localparam int unsigned CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam logic [CW-1:0] TmoMax  = CW'(TMO);
    localparam logic [CW-1:0] TmoLast = CW'((TMO > 0) ? TMO - 1 : 0);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic          pwrite_q, pwrite_d;
    logic          psel_q, psel_d;
    logic          penable_q, penable_d;
    logic [DW-1:0] pwdata_q, pwdata_d;
    logic [SW-1:0] pstrb_q, pstrb_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_tmo_q, rsp_tmo_d;
    logic          cmd_ready;

    assign cmd_ready = (state_q == StIdle) && !preset;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_tmo_d   = rsp_tmo_q;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid && cmd_ready) begin
                    paddr_d  = bus.cmd_addr;
                    pwrite_d = bus.cmd_write;
                    pwdata_d = bus.cmd_wdata;
                    // Strobes carry no meaning on reads, so drive them low.
                    pstrb_d  = bus.cmd_write ? bus.cmd_strb : '0;
                    psel_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                state_d   = StAccess;
            end
            StAccess: begin
                // pready is checked first so a completion beats a coincident timeout.
                if (bus.pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
                    rsp_err_d   = bus.pslverr;
                    rsp_tmo_d   = 1'b0;
                    state_d     = StResp;
                end else if ((TMO != 0) && (cnt_q == TmoLast)) begin
                    cnt_d       = TmoMax;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_tmo_d   = 1'b1;
                    state_d     = StResp;
                end else if (TMO != 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tmo_q   <= rsp_tmo_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.paddr     = paddr_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.pstrb     = pstrb_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_tmo   = rsp_tmo_q;
endmodule
